// File: rtl/note_sequencer.sv
// Melody sequencer: steps a programmable (note, duration) table and
// drives a note code with a silent gap after each entry.
module note_sequencer #(
  parameter int TICK_DIV   = 12_500_000,
  parameter int GAP_CYCLES = 1_000_000,
  parameter int SONG_LEN   = 32,
  parameter int AW         = $clog2(SONG_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [11:0]   wr_data,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  output logic [7:0]    note,
  output logic          busy,
  output logic [AW-1:0] step,
  output logic          done
);

  localparam int MAXC = (15 * TICK_DIV > GAP_CYCLES) ?
                        15 * TICK_DIV : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] GAP_LD = (GAP_CYCLES > 0) ?
                                     CW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP
  } state_t;

  logic [11:0]   r_mem [SONG_LEN];
  state_t        r_state, w_nx_state;
  logic [CW-1:0] r_cnt, w_nx_cnt;
  logic [7:0]    r_note, w_nx_note;
  logic [AW-1:0] r_step, w_nx_step;
  logic          r_done, w_nx_done;

  logic [AW-1:0] w_next;
  logic [11:0]   w_e0;
  logic [11:0]   w_en;
  logic          w_end;
  logic          w_adv;

  // Notes outside 1..96 are played as a rest of the same length
  function automatic logic [7:0] f_note(input logic [7:0] n);
    return (n != 8'd0 && n <= 8'd96) ? n : 8'd0;
  endfunction

  function automatic logic [CW-1:0] f_load(input logic [3:0] d);
    return CW'(d) * CW'(TICK_DIV) - CW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  assign w_next = r_step + AW'(1);
  assign w_e0   = r_mem[0];
  assign w_en   = r_mem[w_next];
  // No wrap-around read past the last slot
  assign w_end  = (r_step == AW'(SONG_LEN - 1)) ||
                  (w_en[11:8] == 4'd0);

  always_comb begin
    w_nx_state = r_state;
    w_nx_cnt   = r_cnt;
    w_nx_note  = r_note;
    w_nx_step  = r_step;
    w_nx_done  = 1'b0;
    w_adv      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_e0[11:8] == 4'd0) begin
            w_nx_done = 1'b1;
          end else begin
            w_nx_state = S_PLAY;
            w_nx_cnt   = f_load(w_e0[11:8]);
            w_nx_note  = f_note(w_e0[7:0]);
            w_nx_step  = '0;
          end
        end
      end
      S_PLAY: begin
        if (r_cnt == '0) begin
          if (GAP_CYCLES > 0) begin
            w_nx_state = S_GAP;
            w_nx_cnt   = GAP_LD;
            w_nx_note  = 8'd0;
          end else begin
            w_adv = 1'b1;
          end
        end else begin
          w_nx_cnt = r_cnt - CW'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == '0) w_adv = 1'b1;
        else             w_nx_cnt = r_cnt - CW'(1);
      end
      default: w_nx_state = S_IDLE;
    endcase

    if (w_adv) begin
      if (w_end) begin
        if (loop && w_e0[11:8] != 4'd0) begin
          w_nx_state = S_PLAY;
          w_nx_cnt   = f_load(w_e0[11:8]);
          w_nx_note  = f_note(w_e0[7:0]);
          w_nx_step  = '0;
        end else begin
          w_nx_state = S_IDLE;
          w_nx_cnt   = '0;
          w_nx_note  = 8'd0;
          w_nx_step  = '0;
          w_nx_done  = 1'b1;
        end
      end else begin
        w_nx_state = S_PLAY;
        w_nx_cnt   = f_load(w_en[11:8]);
        w_nx_note  = f_note(w_en[7:0]);
        w_nx_step  = w_next;
      end
    end

    // Abort overrides start and end-of-song alike
    if (stop) begin
      w_nx_state = S_IDLE;
      w_nx_cnt   = '0;
      w_nx_note  = 8'd0;
      w_nx_step  = '0;
      w_nx_done  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_note  <= 8'd0;
      r_step  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nx_state;
      r_cnt   <= w_nx_cnt;
      r_note  <= w_nx_note;
      r_step  <= w_nx_step;
      r_done  <= w_nx_done;
    end
  end

  assign note = r_note;
  assign busy = (r_state != S_IDLE);
  assign step = r_step;
  assign done = r_done;

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Melody sequencer feeding the PWM tone generator's `note` input. Holds a small programmable song table of (note, duration) entries. On command it steps through the table, presenting each note code for its programmed duration, followed by a short silent articulation gap. Supports single-shot or looped playback, an abort, and a one-cycle completion pulse.

## Interface
Parameters:
- TICK_DIV, 12_500_000, clock cycles per duration unit (1/8 s at 100 MHz)
- GAP_CYCLES, 1_000_000, silent cycles after each entry; 0 disables the gap
- SONG_LEN, 32, table depth; power of two, 2..256
- AW, $clog2(SONG_LEN), address width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset; sampled on rising clk
- wr_en  in  1  table write strobe
- wr_addr  in  AW  table write address
- wr_data  in  12  {dur[3:0], note[7:0]}
- start  in  1  begin playback at entry 0 (level, sampled)
- stop  in  1  abort playback
- loop  in  1  sampled at end of song: 1 = restart at entry 0
- note  out  8  note code to tone generator; 0 = silence
- busy  out  1  high in PLAY or GAP
- step  out  AW  index of entry being played
- done  out  1  one-cycle pulse at natural end of song

## Operation
- Table: SONG_LEN x 12-bit register array, asynchronous read, synchronous write. Writes are accepted in any state. Not cleared by reset. An entry rewritten during playback takes effect the next time it is loaded.
- Entry decode:
  - dur = 0 marks end of song.
  - Note values 1..96 are passed through.
  - Note value 0 or >96 is output as 0 (rest), still held for dur units.
- States:
  - IDLE: note = 0, busy = 0.
    - start=1 and stop=0: load entry 0 and go to PLAY. If entry 0 has dur=0, stay in IDLE and pulse done.
  - PLAY: note = decoded note. The down-counter is loaded with dur*TICK_DIV - 1 (width ≥ clog2(15*TICK_DIV)).
    - Counter reaches 0: go to GAP if GAP_CYCLES > 0, else ADVANCE directly.
  - GAP: note = 0, counter loaded with GAP_CYCLES - 1.
    - Counter reaches 0: ADVANCE.
  - ADVANCE (a transition, not a separate cycle): next = step+1.
    - End of song is reached when step = SONG_LEN-1 (no wrap-around read), or when entry[next] has dur=0.
    - At end of song: loop=1 loads entry 0 and enters PLAY; loop=0 enters IDLE and pulses done.
    - Otherwise: load entry[next] and enter PLAY.
- stop=1 in any state: go to IDLE next cycle with note=0 and step=0. No done pulse. stop wins over a simultaneous start or end-of-song.
- start while busy is ignored.
- Reset (rst=0): state IDLE, note=0, busy=0, step=0, done=0, counters 0. This applies mid-playback too.

## Timing
- Reset values: note=0, busy=0, step=0, done=0.
- start sampled high in IDLE at edge k: from edge k+1, note=entry[0].note, busy=1, step=0.
- Each entry: note held exactly dur*TICK_DIV cycles, then 0 for exactly GAP_CYCLES cycles. The next note appears on the following cycle, with no extra bubble. The period per entry is dur*TICK_DIV + GAP_CYCLES.
- Outputs change only on the clock edge that performs the state transition. step updates on the same edge as the new note.
- done is high for exactly one cycle, coincident with the first IDLE cycle (busy=0, note=0).
- Looping: entry 0 follows the last gap with no idle cycle; done does not pulse.
- stop latency: 1 cycle to note=0, busy=0.

## Test plan
All scenarios use TICK_DIV=4, GAP_CYCLES=2, SONG_LEN=8.
- Reset/idle: hold rst=0 for 5 cycles, then release -> note=0, busy=0, step=0, done=0. Pulsing start with table[0].dur=0 -> no PLAY, done pulses once.
- Basic song: table = {dur2,n49},{dur1,n61},{dur0} with loop=0; pulse start -> note=49 for 8 cycles, 0 for 2, 61 for 4, 0 for 2. Then done=1 for 1 cycle, busy=0. step goes 0,1.
- Rest and range: entries {dur1,n0},{dur1,n120},{dur1,n96} -> note outputs 0, 0, 96, each held 4 cycles with 2-cycle gaps between them.
- Full table wrap: all 8 entries dur1 with loop=1 -> after step=7 and its gap, step=0 and note=entry[0] with no idle cycle, and no done. Then drop loop to 0 -> done pulses after the next step 7.
- Abort and reset: assert stop mid-PLAY -> next cycle note=0, busy=0, done stays 0. Assert start and stop in the same cycle -> stays IDLE. Assert rst=0 mid-GAP -> all outputs at reset values the next cycle.
- Live write: during PLAY of entry 0, write entry 1 = {dur3,n70} -> entry 1 plays note 70 for 12 cycles.
